ntt_butterfly: RTL and testbench

Pipelined, fully streaming Kyber NTT butterfly over q = 3329. It takes one coefficient pair (u, v) and one twiddle zeta per cycle. It computes either a Cooley-Tukey (forward NTT) or a Gentleman-Sande (inverse NTT) butterfly, with an internal Barrett reduction. It sits between the coefficient-memory read port / twiddle ROM and the coefficient-memory write-back, and replaces separate add/sub/mul passes for each butterfly.

---
 rtl/kyber_pkg.sv | 42 ++++
 rtl/ntt_butterfly_if.sv | 31 +++
 rtl/barrett_reduce_pipe.sv | 84 ++++++++
 rtl/ntt_butterfly.sv | 132 +++++++++++++
 tb/tb_ntt_butterfly.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_pkg.sv
// kyber_pkg
// Shared Kyber arithmetic constants, the butterfly mode type and the
// single-step modular add/sub helpers used around the multiplier.
// No ports; imported by the butterfly, its Barrett sub-module and the interface users.
package kyber_pkg;

  localparam int KYBER_Q   = 3329;
  localparam int COEF_W    = 12;
  localparam int BARRETT_M = 5039;   // floor(2^24 / 3329)
  localparam int BARRETT_K = 24;

  localparam int PROD_W = 2 * COEF_W;          // zeta * coefficient
  localparam int T1_W   = 37;                  // product * BARRETT_M
  localparam int RED_W  = 14;                  // Barrett remainder, < 3q

  typedef enum logic {
    BF_CT = 1'b0,
    BF_GS = 1'b1
  } bf_mode_e;

  localparam logic [COEF_W:0] Q_EXT = (COEF_W + 1)'(KYBER_Q);

  // (a + b) mod q for a, b in [0, q-1]: one conditional subtract.
  function automatic logic [COEF_W-1:0] mod_add(input logic [COEF_W-1:0] a,
                                                input logic [COEF_W-1:0] b);
    logic [COEF_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_EXT) s = s - Q_EXT;
    return COEF_W'(s);
  endfunction

  // (a - b) mod q for a, b in [0, q-1]: the wrapped difference plus q
  // lands back in range when a < b.
  function automatic logic [COEF_W-1:0] mod_sub(input logic [COEF_W-1:0] a,
                                                input logic [COEF_W-1:0] b);
    logic [COEF_W:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + Q_EXT;
    return COEF_W'(d);
  endfunction

endpackage

// File: rtl/ntt_butterfly_if.sv
// ntt_butterfly_if
// Streaming input/output handshake bundle for the NTT butterfly.
//   in_valid/in_ready   : input pair handshake
//   mode, u, v, zeta    : operands captured with the input transfer
//   out_valid/out_ready : result handshake
//   out_u, out_v        : results
// Modports: master = producer/consumer side, slave = butterfly side.
interface ntt_butterfly_if #(
  parameter int W = 12
);
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] u;
  logic [W-1:0] v;
  logic [W-1:0] zeta;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_u;
  logic [W-1:0] out_v;

  modport master (
    output in_valid, mode, u, v, zeta, out_ready,
    input  in_ready, out_valid, out_u, out_v
  );

  modport slave (
    input  in_valid, mode, u, v, zeta, out_ready,
    output in_ready, out_valid, out_u, out_v
  );
endinterface

// File: rtl/barrett_reduce_pipe.sv
// barrett_reduce_pipe
// Three-stage Barrett reduction of a 24-bit product modulo 3329, carrying an
// opaque payload alongside. Fixed latency 3 under the shared enable.
//   clk, reset          : clock, async active-high reset
//   en                  : pipeline advance (all stages hold when low)
//   in_valid, p, in_pay : product to reduce and its sideband
//   out_valid, r, out_pay : reduced value in [0, q-1] and its sideband
//   busy                : any stage holds a valid item
module barrett_reduce_pipe
  import kyber_pkg::*;
#(
  parameter int PAY_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] p,
  input  logic [PAY_W-1:0]  in_pay,
  output logic              out_valid,
  output logic [COEF_W-1:0] r,
  output logic [PAY_W-1:0]  out_pay,
  output logic              busy
);

  localparam logic [RED_W-1:0] RED_Q  = RED_W'(KYBER_Q);
  localparam logic [RED_W-1:0] RED_2Q = RED_W'(2 * KYBER_Q);

  logic              s3_valid, s4_valid, s5_valid;
  logic [T1_W-1:0]   s3_t1;
  logic [PROD_W-1:0] s3_p;
  logic [PAY_W-1:0]  s3_pay, s4_pay, s5_pay;
  logic [RED_W-1:0]  s4_r;
  logic [COEF_W-1:0] s5_r;

  logic [RED_W-1:0]  rem_c;
  logic [COEF_W-1:0] red_c;

  // Quotient estimate undershoots the true quotient by at most 2, so the
  // remainder fits below 3q and the low 14 bits of the difference suffice.
  always_comb begin
    logic [PROD_W-1:0] quot;
    quot  = PROD_W'(s3_t1 >> BARRETT_K);
    rem_c = RED_W'(s3_p - quot * PROD_W'(KYBER_Q));
  end

  always_comb begin
    if (s4_r >= RED_2Q)     red_c = COEF_W'(s4_r - RED_2Q);
    else if (s4_r >= RED_Q) red_c = COEF_W'(s4_r - RED_Q);
    else                    red_c = COEF_W'(s4_r);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s3_valid <= 1'b0;
      s4_valid <= 1'b0;
      s5_valid <= 1'b0;
      s3_t1    <= '0;
      s3_p     <= '0;
      s3_pay   <= '0;
      s4_r     <= '0;
      s4_pay   <= '0;
      s5_r     <= '0;
      s5_pay   <= '0;
    end else if (en) begin
      s3_valid <= in_valid;
      s3_t1    <= T1_W'(p) * T1_W'(BARRETT_M);
      s3_p     <= p;
      s3_pay   <= in_pay;
      s4_valid <= s3_valid;
      s4_r     <= rem_c;
      s4_pay   <= s3_pay;
      s5_valid <= s4_valid;
      s5_r     <= red_c;
      s5_pay   <= s4_pay;
    end
  end

  assign out_valid = s5_valid;
  assign r         = s5_r;
  assign out_pay   = s5_pay;
  assign busy      = s3_valid | s4_valid | s5_valid;

endmodule

// File: rtl/ntt_butterfly.sv
// ntt_butterfly
// Six-stage streaming Kyber butterfly over q = 3329. Forward mode (CT)
// computes (u + zeta*v, u - zeta*v); inverse mode (GS) computes
// (u + v, zeta*(u - v)), all mod q. One pair per cycle, in order.
//   clk, reset : clock, async active-high reset
//   bus        : ntt_butterfly_if slave (input/output handshakes and data)
//   busy       : any stage, including the output register, holds a valid item
module ntt_butterfly
  import kyber_pkg::*;
#(
  parameter int W = COEF_W,
  parameter int Q = KYBER_Q
) (
  input  logic                  clk,
  input  logic                  reset,
  ntt_butterfly_if.slave        bus,
  output logic                  busy
);

  if (W != COEF_W || Q != KYBER_Q) begin : g_param_check
    $error("ntt_butterfly supports only W = 12 and Q = 3329");
  end

  localparam int PAY_W = W + 1;

  logic en;
  logic out_valid_q;
  logic [W-1:0] out_u_q, out_v_q;

  // One enable for the whole pipe: bubbles advance so a stalled output is
  // the only thing that can stop the flow.
  assign en           = bus.out_ready | ~out_valid_q;
  assign bus.in_ready = en;

  // S1: pre-add/sub for GS, select multiplicand and pass-through operand.
  logic [W-1:0] sum_c, diff_c;
  always_comb begin
    sum_c  = mod_add(bus.u, bus.v);
    diff_c = mod_sub(bus.u, bus.v);
  end

  logic         s1_valid;
  logic [W-1:0] s1_zeta, s1_mult, s1_pass;
  bf_mode_e     s1_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_zeta  <= '0;
      s1_mult  <= '0;
      s1_pass  <= '0;
      s1_mode  <= BF_CT;
    end else if (en) begin
      s1_valid <= bus.in_valid;
      s1_zeta  <= bus.zeta;
      s1_mode  <= bf_mode_e'(bus.mode);
      s1_mult  <= bus.mode ? diff_c : bus.v;
      s1_pass  <= bus.mode ? sum_c  : bus.u;
    end
  end

  // S2: full 12x12 product.
  logic              s2_valid;
  logic [PROD_W-1:0] s2_p;
  logic [W-1:0]      s2_pass;
  bf_mode_e          s2_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_p     <= '0;
      s2_pass  <= '0;
      s2_mode  <= BF_CT;
    end else if (en) begin
      s2_valid <= s1_valid;
      s2_p     <= PROD_W'(s1_zeta) * PROD_W'(s1_mult);
      s2_pass  <= s1_pass;
      s2_mode  <= s1_mode;
    end
  end

  // S3..S5: Barrett reduction, mode and pass-through ride as payload.
  logic             b_valid, b_busy;
  logic [W-1:0]     b_r;
  logic [PAY_W-1:0] b_pay;
  logic [W-1:0]     b_pass;
  bf_mode_e         b_mode;

  barrett_reduce_pipe #(
    .PAY_W (PAY_W)
  ) u_barrett (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (s2_valid),
    .p         (s2_p),
    .in_pay    ({s2_mode, s2_pass}),
    .out_valid (b_valid),
    .r         (b_r),
    .out_pay   (b_pay),
    .busy      (b_busy)
  );

  assign b_mode = bf_mode_e'(b_pay[W]);
  assign b_pass = b_pay[W-1:0];

  // S6: final add/sub for CT, straight pass for GS; this is the output register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_u_q     <= '0;
      out_v_q     <= '0;
    end else if (en) begin
      out_valid_q <= b_valid;
      if (b_valid) begin
        if (b_mode == BF_GS) begin
          out_u_q <= b_pass;
          out_v_q <= b_r;
        end else begin
          out_u_q <= mod_add(b_pass, b_r);
          out_v_q <= mod_sub(b_pass, b_r);
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_u     = out_u_q;
  assign bus.out_v     = out_v_q;
  assign busy          = s1_valid | s2_valid | b_busy | out_valid_q;

endmodule

// File: tb/tb_ntt_butterfly.sv
// tb_ntt_butterfly
// Directed + randomized bench for ntt_butterfly with a plain-arithmetic
// reference model and an in-order expectation queue.
module tb_ntt_butterfly;

  localparam int Q = 3329;

  logic clk;
  logic reset;
  logic busy;

  ntt_butterfly_if #(.W(12)) bus ();

  ntt_butterfly #(.W(12), .Q(3329)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_edge = -1;
  int n_out = 0;
  logic [23:0] exp_q[$];
  int out_edges[$];
  logic hold_chk = 1'b0;
  logic [11:0] hold_u, hold_v;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] model(input int u, input int v, input int z, input int m);
    int t, ou, ov;
    if (m == 0) begin
      t  = (z * v) % Q;
      ou = (u + t) % Q;
      ov = (u - t + Q) % Q;
    end else begin
      ou = (u + v) % Q;
      ov = (z * ((u - v + Q) % Q)) % Q;
    end
    return {12'(ou), 12'(ov)};
  endfunction

  // One clock: sample handshakes on the falling edge, score on the rising edge.
  task automatic cycle();
    logic acc, otx;
    logic [23:0] e, m;
    @(negedge clk);
    acc = bus.in_valid && bus.in_ready;
    otx = bus.out_valid && bus.out_ready;
    m   = model(int'(bus.u), int'(bus.v), int'(bus.zeta), int'(bus.mode));
    if (hold_chk) begin
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_u", bus.out_u, hold_u);
      chk("hold_v", bus.out_v, hold_v);
    end
    if (bus.out_valid && !bus.out_ready) chk("in_ready_stall", bus.in_ready, 0);
    hold_chk = bus.out_valid && !bus.out_ready;
    hold_u   = bus.out_u;
    hold_v   = bus.out_v;
    if (otx) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL spurious_out: observed u=%0d v=%0d expected no result", bus.out_u, bus.out_v);
      end else begin
        e = exp_q.pop_front();
        chk("out_u", bus.out_u, e[23:12]);
        chk("out_v", bus.out_v, e[11:0]);
      end
    end
    @(posedge clk);
    cyc++;
    if (acc) begin
      exp_q.push_back(m);
      last_acc_edge = cyc;
    end
    if (otx) out_edges.push_back(cyc);
    #1;
  endtask

  task automatic drive(input int u, input int v, input int z, input int m);
    bus.u    = 12'(u);
    bus.v    = 12'(v);
    bus.zeta = 12'(z);
    bus.mode = m[0];
  endtask

  task automatic rand_drive();
    drive(int'($urandom_range(0, Q-1)), int'($urandom_range(0, Q-1)),
          int'($urandom_range(0, Q-1)), int'($urandom_range(0, 1)));
  endtask

  task automatic single(input string tag, input int u, input int v, input int z, input int m,
                        input int eu, input int ev);
    int lat;
    drive(u, v, z, m);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    chk({tag, "_accept"}, last_acc_edge, cyc);
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    chk({tag, "_latency"}, lat, 5);
    chk({tag, "_u"}, bus.out_u, eu);
    chk({tag, "_v"}, bus.out_v, ev);
    cycle();
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  // Stream n random items back-to-back; out_ready drops for stall_len
  // cycles starting stall_at cycles into the stream.
  task automatic stream(input int n, input int stall_at, input int stall_len, output int first_acc);
    int sent, k;
    sent = 0;
    k = 0;
    first_acc = -1;
    rand_drive();
    bus.in_valid = 1'b1;
    while (sent < n && k < 200) begin
      bus.out_ready = !(k >= stall_at && k < stall_at + stall_len);
      cycle();
      k++;
      if (last_acc_edge == cyc) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
        rand_drive();
      end
    end
    chk("stream_sent", sent, n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    k = 0;
    while (exp_q.size() > 0 && k < 100) begin
      cycle();
      k++;
    end
    chk("stream_drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int fa, n0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    drive(0, 0, 0, 0);
    #12;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_u", bus.out_u, 0);
    chk("rst_out_v", bus.out_v, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1 reset = 1'b0;

    single("ct_single", 100, 200, 17, 0, 171, 29);
    single("gs_single", 100, 200, 17, 1, 300, 1629);
    single("ct_bound", 0, 3328, 3328, 0, 1, 3328);
    single("gs_bound", 3328, 3328, 3328, 1, 3327, 0);
    chk("idle_busy", busy, 0);

    // Full-rate stream: 8 results on 8 consecutive edges, 6 edges after the first accept.
    out_edges.delete();
    n0 = n_out;
    stream(8, 1000, 0, fa);
    chk("stream_count", n_out - n0, 8);
    chk("stream_first", out_edges[0], fa + 6);
    chk("stream_contig", out_edges[7] - out_edges[0], 7);

    // Backpressure mid-stream.
    n0 = n_out;
    stream(10, 6, 3, fa);
    chk("bp_count", n_out - n0, 10);

    // A few more random streams with random stalls.
    for (int i = 0; i < 3; i++) begin
      n0 = n_out;
      stream(12, int'($urandom_range(2, 9)), int'($urandom_range(1, 4)), fa);
      chk("rand_count", n_out - n0, 12);
    end

    // Reset with items in flight, first one already at the output.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rand_drive();
      bus.in_valid = 1'b1;
      cycle();
    end
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_valid", bus.out_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    hold_chk = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 8; i++) cycle();
    chk("no_stale", n_out - n0, 0);
    begin
      int ru, rv, rz, rm;
      logic [23:0] e;
      ru = int'($urandom_range(0, Q-1));
      rv = int'($urandom_range(0, Q-1));
      rz = int'($urandom_range(0, Q-1));
      rm = int'($urandom_range(0, 1));
      e  = model(ru, rv, rz, rm);
      single("post_rst", ru, rv, rz, rm, int'(e[23:12]), int'(e[11:0]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
